// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath width, fixed instruction
// encodings and the fetch-stage state encoding.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    VALID  = 2'd1,
    HALTED = 2'd2,
    FAULT  = 2'd3
  } fetch_state_t;

endpackage : riscv_pkg

// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/response bundle. The fetch stage is the
// master (drives the request and address); the memory is the slave.
interface instruction_fetch_if;
  import riscv_pkg::*;

  logic             imem_req;
  logic [XLEN-1:0]  imem_addr;
  logic             imem_ready;
  logic [31:0]      imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface : instruction_fetch_if

// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, requests one instruction at a time from
// instruction memory, presents it to decode, and follows execute-stage
// redirects. Stops permanently (until reset) on EBREAK or on a redirect
// to a non-word-aligned target.
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic                 clk,
  input  logic                 reset,          // active-low, synchronous
  instruction_fetch_if.master  imem,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [XLEN-1:0]      branch_target,
  output logic [31:0]          instruction,
  output logic [XLEN-1:0]      pc,
  output logic [XLEN-1:0]      pc_plus4,
  output logic                 instr_valid,
  output logic                 halted,
  output logic                 misaligned_fault
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            halted_q, halted_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] pc_inc;

  // Link address and sequential next PC; wraps naturally modulo 2^XLEN.
  assign pc_inc = pc_q + XLEN'(4);

  // Next-state and next-PC selection for the fetch FSM.
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    halted_d = halted_q;
    fault_d  = fault_q;

    unique case (state_q)
      FETCH: begin
        if (imem.imem_ready) begin
          instr_d = imem.imem_rdata;
          state_d = VALID;
        end
      end

      VALID: begin
        // A stall freezes everything, including any redirect request.
        if (!stall) begin
          if (instr_q == EBREAK_INSTR) begin
            halted_d = 1'b1;
            state_d  = HALTED;
          end else if (branch_taken && (branch_target[1:0] != 2'b00)) begin
            fault_d = 1'b1;
            state_d = FAULT;
          end else begin
            pc_d    = branch_taken ? branch_target : pc_inc;
            state_d = FETCH;
          end
        end
      end

      // HALTED and FAULT are terminal; only reset leaves them.
      HALTED, FAULT: begin
        state_d = state_q;
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC[XLEN-1:0];
      instr_q  <= NOP_INSTR;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

  // The request is suppressed while reset is asserted so a request is never
  // seen during the reset cycle.
  assign imem.imem_req  = (state_q == FETCH) && reset;
  assign imem.imem_addr = pc_q;

  assign instruction      = instr_q;
  assign pc               = pc_q;
  assign pc_plus4         = pc_inc;
  assign instr_valid      = (state_q == VALID);
  assign halted           = halted_q;
  assign misaligned_fault = fault_q;

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch. Inputs are driven and
// outputs sampled on the falling clock edge, away from the active edge.
module tb_instruction_fetch;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        halted;
  logic        misaligned_fault;

  int checks = 0;
  int errors = 0;

  instruction_fetch_if imem_bus ();

  instruction_fetch #(
    .RESET_PC (32'h0000_0000),
    .XLEN     (32)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .imem             (imem_bus.master),
    .stall            (stall),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .instruction      (instruction),
    .pc               (pc),
    .pc_plus4         (pc_plus4),
    .instr_valid      (instr_valid),
    .halted           (halted),
    .misaligned_fault (misaligned_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Memory-side driver: set ready and data for the coming clock edge.
  task automatic mem(input logic rdy, input logic [31:0] data);
    imem_bus.imem_ready = rdy;
    imem_bus.imem_rdata = data;
  endtask

  initial begin
    reset         = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    mem(1'b0, 32'h0);

    // ---- Reset values ----
    tick(); tick();
    check("rst_pc",     pc,                32'h0);
    check("rst_instr",  instruction,       NOP_INSTR);
    check("rst_valid",  {31'd0, instr_valid},      32'd0);
    check("rst_halted", {31'd0, halted},           32'd0);
    check("rst_fault",  {31'd0, misaligned_fault}, 32'd0);
    check("rst_req",    {31'd0, imem_bus.imem_req}, 32'd0);

    // ---- 1: zero-wait memory, two sequential instructions ----
    reset = 1'b1;
    mem(1'b1, 32'h0020_81B3);
    #1;
    check("t1_req0",  {31'd0, imem_bus.imem_req}, 32'd1);
    check("t1_addr0", imem_bus.imem_addr, 32'h0);
    tick();
    check("t1_valid0", {31'd0, instr_valid}, 32'd1);
    check("t1_instr0", instruction, 32'h0020_81B3);
    check("t1_pc0",    pc,          32'h0);
    check("t1_pc4_0",  pc_plus4,    32'h4);
    check("t1_noreq0", {31'd0, imem_bus.imem_req}, 32'd0);
    mem(1'b1, 32'h4032_02B3);  // stray ready while in VALID
    tick();
    check("t1_req1",    {31'd0, imem_bus.imem_req}, 32'd1);
    check("t1_addr1",   imem_bus.imem_addr, 32'h4);
    check("t1_nvalid1", {31'd0, instr_valid}, 32'd0);
    tick();
    check("t1_valid1", {31'd0, instr_valid}, 32'd1);
    check("t1_instr1", instruction, 32'h4032_02B3);
    check("t1_pc1",    pc,          32'h4);
    check("t1_pc4_1",  pc_plus4,    32'h8);
    mem(1'b0, 32'hDEAD_BEEF);

    // ---- 2: ready delayed by 3 cycles ----
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_req",    {31'd0, imem_bus.imem_req}, 32'd1);
      check("t2_addr",   imem_bus.imem_addr, 32'h8);
      check("t2_nvalid", {31'd0, instr_valid}, 32'd0);
    end
    mem(1'b1, 32'h0010_0093);
    tick();
    check("t2_valid", {31'd0, instr_valid}, 32'd1);
    check("t2_instr", instruction, 32'h0010_0093);
    check("t2_pc",    pc,          32'h8);

    // ---- 3: stall for 5 cycles with branch_taken toggling ----
    mem(1'b0, 32'h0);
    stall         = 1'b1;
    branch_target = 32'h0000_0200;
    for (int i = 0; i < 5; i++) begin
      branch_taken = ~branch_taken;
      tick();
      check("t3_valid", {31'd0, instr_valid}, 32'd1);
      check("t3_instr", instruction, 32'h0010_0093);
      check("t3_pc",    pc,          32'h8);
      check("t3_noreq", {31'd0, imem_bus.imem_req}, 32'd0);
    end
    stall        = 1'b0;
    branch_taken = 1'b0;
    tick();
    check("t3_addr", imem_bus.imem_addr, 32'hC);
    check("t3_req",  {31'd0, imem_bus.imem_req}, 32'd1);

    // ---- 4: aligned redirect, branch ignored outside VALID ----
    mem(1'b1, NOP_INSTR);
    tick();
    check("t4_pc_c", pc, 32'hC);
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0100;
    mem(1'b0, 32'h0);
    tick();
    check("t4_addr", imem_bus.imem_addr, 32'h100);
    check("t4_req",  {31'd0, imem_bus.imem_req}, 32'd1);
    branch_target = 32'h0000_0300;  // stray redirect during FETCH
    mem(1'b1, NOP_INSTR);
    tick();
    check("t4_pc",   pc,       32'h100);
    check("t4_pc4",  pc_plus4, 32'h104);

    // ---- 6: redirect to 0xFFFFFFFC then sequential wrap ----
    branch_taken  = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    mem(1'b0, 32'h0);
    tick();
    check("t6_addr_top", imem_bus.imem_addr, 32'hFFFF_FFFC);
    branch_taken = 1'b0;
    mem(1'b1, NOP_INSTR);
    tick();
    check("t6_pc_top",  pc,       32'hFFFF_FFFC);
    check("t6_pc4_wrap", pc_plus4, 32'h0);
    mem(1'b0, 32'h0);
    tick();
    check("t6_addr_wrap", imem_bus.imem_addr, 32'h0);
    check("t6_nofault",   {31'd0, misaligned_fault}, 32'd0);

    // ---- 4b: misaligned redirect -> FAULT ----
    mem(1'b1, NOP_INSTR);
    tick();
    check("t4b_valid", {31'd0, instr_valid}, 32'd1);
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0102;
    tick();
    check("t4b_fault",  {31'd0, misaligned_fault}, 32'd1);
    check("t4b_nvalid", {31'd0, instr_valid}, 32'd0);
    check("t4b_noreq",  {31'd0, imem_bus.imem_req}, 32'd0);
    check("t4b_pc",     pc, 32'h0);
    branch_taken = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t4b_stuck_req",   {31'd0, imem_bus.imem_req}, 32'd0);
      check("t4b_stuck_fault", {31'd0, misaligned_fault}, 32'd1);
    end

    // ---- Reset out of FAULT ----
    reset = 1'b0;
    mem(1'b0, 32'h0);
    tick();
    check("rf_fault", {31'd0, misaligned_fault}, 32'd0);
    reset = 1'b1;

    // ---- 5: EBREAK at pc 4, beats a misaligned redirect ----
    mem(1'b1, NOP_INSTR);
    tick();
    check("t5_pc0", pc, 32'h0);
    mem(1'b0, 32'h0);
    tick();
    check("t5_addr4", imem_bus.imem_addr, 32'h4);
    mem(1'b1, EBREAK_INSTR);
    tick();
    check("t5_instr", instruction, EBREAK_INSTR);
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0102;
    mem(1'b0, 32'h0);
    tick();
    check("t5_halted", {31'd0, halted}, 32'd1);
    check("t5_nofault", {31'd0, misaligned_fault}, 32'd0);
    check("t5_pc",     pc, 32'h4);
    check("t5_noreq",  {31'd0, imem_bus.imem_req}, 32'd0);
    check("t5_nvalid", {31'd0, instr_valid}, 32'd0);
    branch_taken = 1'b0;
    mem(1'b1, NOP_INSTR);
    tick();
    check("t5_sticky", {31'd0, halted}, 32'd1);

    // One-cycle reset pulse with a stray ready in the reset cycle.
    reset = 1'b0;
    mem(1'b1, 32'h1234_5678);
    #1;
    check("t5_rst_noreq", {31'd0, imem_bus.imem_req}, 32'd0);
    tick();
    check("t5_rst_halted", {31'd0, halted}, 32'd0);
    check("t5_rst_pc",     pc, 32'h0);
    check("t5_rst_instr",  instruction, NOP_INSTR);
    check("t5_rst_nvalid", {31'd0, instr_valid}, 32'd0);
    reset = 1'b1;
    mem(1'b1, 32'h0050_0113);
    #1;
    check("t5_restart_req",  {31'd0, imem_bus.imem_req}, 32'd1);
    check("t5_restart_addr", imem_bus.imem_addr, 32'h0);
    tick();
    check("t5_restart_valid", {31'd0, instr_valid}, 32'd1);
    check("t5_restart_instr", instruction, 32'h0050_0113);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_instruction_fetch
